// File: rtl/irq_pkg.sv
// Shared types and constants for the priority interrupt controller.
package irq_pkg;

  localparam int IRQ_PRIO_W        = 3;
  localparam int IRQ_PRIO_DISABLED = 0;

  typedef struct packed {
    logic                  edge_mode;
    logic [IRQ_PRIO_W-1:0] prio;
  } irq_src_cfg_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_e;

  function automatic int irq_vec_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational max-priority arbiter; equal priorities resolve to the lowest index.
module irq_prio_arb
  import irq_pkg::*;
#(
  parameter  int N      = 32,
  parameter  int PRIO_W = IRQ_PRIO_W,
  localparam int VEC_W  = irq_vec_w(N)
) (
  input  logic [N-1:0]             req,
  input  logic [N-1:0][PRIO_W-1:0] prio,
  output logic                     any,
  output logic [VEC_W-1:0]         win_idx,
  output logic [PRIO_W-1:0]        win_prio
);

  localparam int LEAVES = 1 << VEC_W;
  localparam int NODES  = 2 * LEAVES - 1;

  logic              node_vld  [NODES];
  logic [VEC_W-1:0]  node_idx  [NODES];
  logic [PRIO_W-1:0] node_prio [NODES];

  // Heap-ordered tree: leaves sit at LEAVES-1+i, the left child always holds
  // lower indices, so the right child only wins on strictly higher priority.
  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      node_vld[k]  = 1'b0;
      node_idx[k]  = '0;
      node_prio[k] = '0;
    end
    for (int i = 0; i < LEAVES; i++) begin
      if (i < N) begin
        node_vld[LEAVES-1+i]  = req[i];
        node_idx[LEAVES-1+i]  = VEC_W'(i);
        node_prio[LEAVES-1+i] = prio[i];
      end
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (node_vld[2*k+2] && (!node_vld[2*k+1] || node_prio[2*k+2] > node_prio[2*k+1])) begin
        node_vld[k]  = 1'b1;
        node_idx[k]  = node_idx[2*k+2];
        node_prio[k] = node_prio[2*k+2];
      end else begin
        node_vld[k]  = node_vld[2*k+1];
        node_idx[k]  = node_idx[2*k+1];
        node_prio[k] = node_prio[2*k+1];
      end
    end
  end

  assign any      = node_vld[0];
  assign win_idx  = node_idx[0];
  assign win_prio = node_prio[0];

endmodule

// File: rtl/irq_prio_ctrl.sv
// N-source interrupt controller: per-source edge/level mode and priority,
// global threshold, held presentation until a matching ack.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter  int N      = 32,
  parameter  int PRIO_W = IRQ_PRIO_W,
  localparam int VEC_W  = irq_vec_w(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      src_irq,
  input  logic              cfg_wr,
  input  logic [VEC_W-1:0]  cfg_idx,
  input  logic              cfg_edge,
  input  logic [PRIO_W-1:0] cfg_prio,
  input  logic [PRIO_W-1:0] prio_threshold,
  output logic              irq_valid,
  output logic [VEC_W-1:0]  irq_vector,
  output logic [PRIO_W-1:0] irq_prio,
  output logic [N-1:0]      irq_pending,
  input  logic              irq_ack,
  input  logic [VEC_W-1:0]  irq_ack_vector,
  output logic              ack_err
);

  localparam logic [PRIO_W-1:0] PRIO_OFF = PRIO_W'(IRQ_PRIO_DISABLED);

  logic [N-1:0]             edge_q, edge_d;
  logic [N-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [N-1:0]             src_q;
  logic [N-1:0]             pending_q, pending_d;
  logic [N-1:0]             irq_pending_q, irq_pending_d;
  logic [N-1:0]             elig;
  irq_state_e               state_q, state_d;
  logic                     valid_q, valid_d;
  logic [VEC_W-1:0]         vector_q, vector_d;
  logic [PRIO_W-1:0]        vprio_q, vprio_d;
  logic                     ack_err_q, ack_err_d;

  logic                     cfg_hit;
  logic                     ack_ok;
  logic                     arb_any;
  logic [VEC_W-1:0]         arb_idx;
  logic [PRIO_W-1:0]        arb_prio;

  assign cfg_hit = cfg_wr && (int'(cfg_idx) < N);
  assign ack_ok  = irq_ack && valid_q && (irq_ack_vector == vector_q);

  always_comb begin
    edge_d = edge_q;
    prio_d = prio_q;
    if (cfg_hit) begin
      edge_d[cfg_idx] = cfg_edge;
      prio_d[cfg_idx] = cfg_prio;
    end
  end

  // Edge sources: a fresh edge beats a simultaneous ack so it is not lost.
  // Level sources simply track the line; ack cannot clear them.
  always_comb begin
    pending_d     = '0;
    irq_pending_d = '0;
    elig          = '0;
    for (int i = 0; i < N; i++) begin
      if (edge_q[i]) begin
        pending_d[i] = (src_irq[i] & ~src_q[i]) |
                       (pending_q[i] & ~(ack_ok && (vector_q == VEC_W'(i))));
      end else begin
        pending_d[i] = src_irq[i];
      end
      if (cfg_hit && (cfg_idx == VEC_W'(i)) && (cfg_edge != edge_q[i])) begin
        pending_d[i] = 1'b0;
      end
      irq_pending_d[i] = pending_d[i] && (prio_d[i] != PRIO_OFF);
      elig[i] = pending_q[i] && (prio_q[i] != PRIO_OFF) && (prio_q[i] > prio_threshold);
    end
  end

  irq_prio_arb #(
    .N      (N),
    .PRIO_W (PRIO_W)
  ) u_arb (
    .req      (elig),
    .prio     (prio_q),
    .any      (arb_any),
    .win_idx  (arb_idx),
    .win_prio (arb_prio)
  );

  // A presented vector is held, never preempted or retracted, until acked.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    vector_d  = vector_q;
    vprio_d   = vprio_q;
    ack_err_d = irq_ack && !ack_ok;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          valid_d  = 1'b1;
          vector_d = arb_idx;
          vprio_d  = arb_prio;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ack_ok) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q        <= '0;
      prio_q        <= '0;
      src_q         <= '1;
      pending_q     <= '0;
      irq_pending_q <= '0;
      state_q       <= ST_IDLE;
      valid_q       <= 1'b0;
      vector_q      <= '0;
      vprio_q       <= '0;
      ack_err_q     <= 1'b0;
    end else begin
      edge_q        <= edge_d;
      prio_q        <= prio_d;
      src_q         <= src_irq;
      pending_q     <= pending_d;
      irq_pending_q <= irq_pending_d;
      state_q       <= state_d;
      valid_q       <= valid_d;
      vector_q      <= vector_d;
      vprio_q       <= vprio_d;
      ack_err_q     <= ack_err_d;
    end
  end

  assign irq_valid   = valid_q;
  assign irq_vector  = vector_q;
  assign irq_prio    = vprio_q;
  assign irq_pending = irq_pending_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl with hand-computed expectations.
module tb_irq_prio_ctrl;

  localparam int N      = 32;
  localparam int PRIO_W = 3;
  localparam int VEC_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      src_irq;
  logic              cfg_wr;
  logic [VEC_W-1:0]  cfg_idx;
  logic              cfg_edge;
  logic [PRIO_W-1:0] cfg_prio;
  logic [PRIO_W-1:0] prio_threshold;
  logic              irq_valid;
  logic [VEC_W-1:0]  irq_vector;
  logic [PRIO_W-1:0] irq_prio;
  logic [N-1:0]      irq_pending;
  logic              irq_ack;
  logic [VEC_W-1:0]  irq_ack_vector;
  logic              ack_err;

  int checks = 0;
  int errors = 0;

  irq_prio_ctrl #(.N(N), .PRIO_W(PRIO_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_irq        (src_irq),
    .cfg_wr         (cfg_wr),
    .cfg_idx        (cfg_idx),
    .cfg_edge       (cfg_edge),
    .cfg_prio       (cfg_prio),
    .prio_threshold (prio_threshold),
    .irq_valid      (irq_valid),
    .irq_vector     (irq_vector),
    .irq_prio       (irq_prio),
    .irq_pending    (irq_pending),
    .irq_ack        (irq_ack),
    .irq_ack_vector (irq_ack_vector),
    .ack_err        (ack_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic e, input int p);
    cfg_wr   = 1'b1;
    cfg_idx  = VEC_W'(idx);
    cfg_edge = e;
    cfg_prio = PRIO_W'(p);
    step();
    cfg_wr   = 1'b0;
  endtask

  task automatic do_ack(input int v);
    irq_ack        = 1'b1;
    irq_ack_vector = VEC_W'(v);
    step();
    irq_ack        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_irq = '0; cfg_wr = 0; cfg_idx = '0; cfg_edge = 0; cfg_prio = '0;
    prio_threshold = '0; irq_ack = 0; irq_ack_vector = '0;
    step(); step();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", irq_valid); end
    checks++; if (irq_pending !== '0) begin errors++; $display("FAIL reset_pending: got %h want 0", irq_pending); end
    checks++; if (irq_vector !== '0 || irq_prio !== '0 || ack_err !== 1'b0) begin errors++;
      $display("FAIL reset_outs: vec %0d prio %0d err %0b want 0 0 0", irq_vector, irq_prio, ack_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    cfg_write(5, 1'b1, 3);
    src_irq[5] = 1'b1;
    step();
    checks++; if (irq_pending[5] !== 1'b1) begin errors++; $display("FAIL basic_pending: got %0b want 1", irq_pending[5]); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", irq_valid); end
    src_irq[5] = 1'b0;
    step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd5 || irq_prio !== 3'd3) begin errors++;
      $display("FAIL basic_present: valid %0b vec %0d prio %0d want 1 5 3", irq_valid, irq_vector, irq_prio); end
    do_ack(5);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_drop: got %0b want 0", irq_valid); end
    step();
    checks++; if (irq_valid !== 1'b0 || irq_pending[5] !== 1'b0) begin errors++;
      $display("FAIL basic_idle: valid %0b pend %0b want 0 0", irq_valid, irq_pending[5]); end
  endtask

  task automatic test_tie();
    cfg_write(2, 1'b1, 4);
    cfg_write(9, 1'b1, 4);
    src_irq[2] = 1'b1; src_irq[9] = 1'b1;
    step();
    src_irq[2] = 1'b0; src_irq[9] = 1'b0;
    step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd2 || irq_prio !== 3'd4) begin errors++;
      $display("FAIL tie_first: valid %0b vec %0d prio %0d want 1 2 4", irq_valid, irq_vector, irq_prio); end
    do_ack(2);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL tie_bubble: got %0b want 0", irq_valid); end
    step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd9) begin errors++;
      $display("FAIL tie_second: valid %0b vec %0d want 1 9", irq_valid, irq_vector); end
    do_ack(9);
    step();
  endtask

  task automatic test_no_preempt_and_bad_ack();
    cfg_write(7, 1'b1, 6);
    cfg_write(1, 1'b1, 7);
    src_irq[7] = 1'b1; step(); src_irq[7] = 1'b0; step();
    checks++; if (irq_vector !== 5'd7 || irq_valid !== 1'b1) begin errors++;
      $display("FAIL preempt_first: valid %0b vec %0d want 1 7", irq_valid, irq_vector); end
    src_irq[1] = 1'b1; step(); src_irq[1] = 1'b0; step();
    checks++; if (irq_vector !== 5'd7 || irq_prio !== 3'd6 || irq_valid !== 1'b1) begin errors++;
      $display("FAIL preempt_hold: valid %0b vec %0d prio %0d want 1 7 6", irq_valid, irq_vector, irq_prio); end
    do_ack(3);
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL bad_ack_err: got %0b want 1", ack_err); end
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd7) begin errors++;
      $display("FAIL bad_ack_hold: valid %0b vec %0d want 1 7", irq_valid, irq_vector); end
    step();
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL bad_ack_pulse: got %0b want 0", ack_err); end
    do_ack(7);
    checks++; if (irq_valid !== 1'b0 || ack_err !== 1'b0) begin errors++;
      $display("FAIL preempt_ack: valid %0b err %0b want 0 0", irq_valid, ack_err); end
    step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd1 || irq_prio !== 3'd7) begin errors++;
      $display("FAIL preempt_next: valid %0b vec %0d prio %0d want 1 1 7", irq_valid, irq_vector, irq_prio); end
    do_ack(1);
    step();
    do_ack(1);
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL idle_ack_err: got %0b want 1", ack_err); end
    step();
  endtask

  task automatic test_level_threshold();
    cfg_write(4, 1'b0, 2);
    prio_threshold = 3'd2;
    src_irq[4] = 1'b1;
    step(); step(); step();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL thresh_block: got %0b want 0", irq_valid); end
    checks++; if (irq_pending[4] !== 1'b1) begin errors++; $display("FAIL level_pending: got %0b want 1", irq_pending[4]); end
    prio_threshold = 3'd1;
    step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd4 || irq_prio !== 3'd2) begin errors++;
      $display("FAIL level_present: valid %0b vec %0d prio %0d want 1 4 2", irq_valid, irq_vector, irq_prio); end
    do_ack(4);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL level_bubble: got %0b want 0", irq_valid); end
    step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd4) begin errors++;
      $display("FAIL level_represent: valid %0b vec %0d want 1 4", irq_valid, irq_vector); end
    src_irq[4] = 1'b0;
    do_ack(4);
    step(); step();
    checks++; if (irq_valid !== 1'b0 || irq_pending[4] !== 1'b0) begin errors++;
      $display("FAIL level_stop: valid %0b pend %0b want 0 0", irq_valid, irq_pending[4]); end
    prio_threshold = 3'd0;
  endtask

  task automatic test_back_to_back_and_async_reset();
    src_irq[5] = 1'b1; step(); src_irq[5] = 1'b0; step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd5) begin errors++;
      $display("FAIL b2b_first: valid %0b vec %0d want 1 5", irq_valid, irq_vector); end
    src_irq[5] = 1'b1;
    do_ack(5);
    src_irq[5] = 1'b0;
    checks++; if (irq_valid !== 1'b0 || irq_pending[5] !== 1'b1) begin errors++;
      $display("FAIL b2b_retain: valid %0b pend %0b want 0 1", irq_valid, irq_pending[5]); end
    step();
    checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd5) begin errors++;
      $display("FAIL b2b_represent: valid %0b vec %0d want 1 5", irq_valid, irq_vector); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (irq_valid !== 1'b0 || irq_vector !== '0 || irq_prio !== '0 || irq_pending !== '0) begin errors++;
      $display("FAIL async_reset: valid %0b vec %0d prio %0d pend %h want all 0", irq_valid, irq_vector, irq_prio, irq_pending); end
    step();
    rst_n = 1'b1;
    src_irq[5] = 1'b1;
    step(); step(); step();
    checks++; if (irq_valid !== 1'b0 || irq_pending !== '0) begin errors++;
      $display("FAIL post_reset_cfg: valid %0b pend %h want 0 0", irq_valid, irq_pending); end
    src_irq[5] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_no_preempt_and_bad_ack();
    test_level_threshold();
    test_back_to_back_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
